// File: rtl/spi_flash_reader.sv
// SPI mode-0 master that issues a 03h read and returns one 32-bit word per request.
// Optional byte swap of the returned word: define SPI_FLASH_RD_BSWAP_EN.
module spi_flash_reader #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [23:0] req_addr,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        sck,
  output logic        ss,
  output logic        mosi,
  input  logic        miso
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, RESP} state_t;

  localparam logic [7:0] DIV_RELOAD = 8'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] tx_q, tx_d;
  logic [31:0] rx_q, rx_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        sck_q, sck_d;
  logic        ss_q, ss_d;
  logic        mosi_q, mosi_d;
  logic        resp_valid_q, resp_valid_d;

  logic        half_done;
  logic [31:0] load_word;
  logic [31:0] rx_ordered;

  assign half_done = (div_q == 8'd0);
  assign load_word = {8'h03, req_addr};

`ifdef SPI_FLASH_RD_BSWAP_EN
  assign rx_ordered = {rx_q[7:0], rx_q[15:8], rx_q[23:16], rx_q[31:24]};
`else
  assign rx_ordered = rx_q;
`endif

  // Ready is combinational so it drops the moment reset is asserted.
  assign req_ready  = (state_q == IDLE) && !reset;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign sck        = sck_q;
  assign ss         = ss_q;
  assign mosi       = mosi_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      div_q        <= 8'd0;
      bit_cnt_q    <= 6'd0;
      tx_q         <= 32'd0;
      rx_q         <= 32'd0;
      resp_data_q  <= 32'd0;
      sck_q        <= 1'b0;
      ss_q         <= 1'b1;
      mosi_q       <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      bit_cnt_q    <= bit_cnt_d;
      tx_q         <= tx_d;
      rx_q         <= rx_d;
      resp_data_q  <= resp_data_d;
      sck_q        <= sck_d;
      ss_q         <= ss_d;
      mosi_q       <= mosi_d;
      resp_valid_q <= resp_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = div_q;
    bit_cnt_d    = bit_cnt_q;
    tx_d         = tx_q;
    rx_d         = rx_q;
    resp_data_d  = resp_data_q;
    sck_d        = sck_q;
    ss_d         = ss_q;
    mosi_d       = mosi_q;
    resp_valid_d = resp_valid_q;

    unique case (state_q)
      IDLE: begin
        sck_d = 1'b0;
        ss_d  = 1'b1;
        if (req_valid) begin
          tx_d      = load_word;
          rx_d      = 32'd0;
          bit_cnt_d = 6'd0;
          ss_d      = 1'b0;
          mosi_d    = load_word[31];
          div_d     = DIV_RELOAD;
          state_d   = SETUP;
        end
      end

      SETUP: begin
        if (half_done) begin
          div_d   = DIV_RELOAD;
          state_d = SHIFT;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      // Rising toggle samples miso for the data phase; falling toggle advances the bit.
      SHIFT: begin
        if (half_done) begin
          div_d = DIV_RELOAD;
          sck_d = ~sck_q;
          if (!sck_q) begin
            if (bit_cnt_q[5]) begin
              rx_d = {rx_q[30:0], miso};
            end
          end else begin
            tx_d   = {tx_q[30:0], 1'b0};
            mosi_d = tx_q[30];
            if (bit_cnt_q == 6'd63) begin
              state_d = HOLD;
            end else begin
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      HOLD: begin
        if (half_done) begin
          ss_d         = 1'b1;
          resp_valid_d = 1'b1;
          resp_data_d  = rx_ordered;
          state_d      = RESP;
        end else begin
          div_d = div_q - 8'd1;
        end
      end

      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_spi_flash_reader.sv
// Self-checking bench for spi_flash_reader with a behavioural serial NOR flash model.
// Expected words follow SPI_FLASH_RD_BSWAP_EN the same way the design does.
module tb_spi_flash_reader;

  localparam int DIV = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [23:0] req_addr;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic        sck;
  logic        ss;
  logic        mosi;
  logic        miso = 1'b0;

  spi_flash_reader #(.CLK_DIV(DIV)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .sck        (sck),
    .ss         (ss),
    .mosi       (mosi),
    .miso       (miso)
  );

  always #5 clock = ~clock;

  logic [7:0]  mem [0:4095];
  int          rise_cnt = 0;
  int          last_rises = 0;
  int          stray_rises = 0;
  logic        prev_sck = 1'b0;
  logic [31:0] shift_in = 32'd0;
  logic [31:0] stream = 32'd0;
  logic [7:0]  cap_cmd = 8'd0;
  logic [23:0] cap_addr = 24'd0;

  int          cyc = 0;
  int          hs_cyc = 0;
  int          busy_ready = 0;
  int          high_run = 0;
  int          last_gap = 0;
  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_addr = 24'd0;

  // Flash: latch command/address on rising sck, drive data bytes MSB first while sck is low.
  always @(sck or ss) begin
    logic [11:0] base;
    if (ss !== 1'b0) begin
      if (sck === 1'b1 && prev_sck === 1'b0) stray_rises++;
      if (rise_cnt != 0) last_rises = rise_cnt;
      rise_cnt = 0;
    end else if (sck === 1'b1 && prev_sck !== 1'b1) begin
      if (rise_cnt < 32) shift_in = {shift_in[30:0], mosi};
      rise_cnt++;
    end else if (sck === 1'b0 && prev_sck === 1'b1) begin
      if (rise_cnt == 32) begin
        cap_cmd  = shift_in[31:24];
        cap_addr = shift_in[23:0];
        base     = shift_in[11:0];
        stream   = {mem[base], mem[base + 12'd1], mem[base + 12'd2], mem[base + 12'd3]};
      end
      if (rise_cnt >= 32 && rise_cnt < 64) miso = stream[63 - rise_cnt];
    end
    prev_sck = sck;
  end

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (ss === 1'b0 && req_ready === 1'b1) busy_ready++;
    if (ss === 1'b1) begin
      high_run++;
    end else if (ss === 1'b0) begin
      if (high_run > 0) last_gap = high_run;
      high_run = 0;
    end
  end

  function automatic logic [31:0] expWord(input logic [23:0] a);
    logic [11:0] base;
    logic [7:0]  b0, b1, b2, b3;
    base = a[11:0];
    b0 = mem[base];
    b1 = mem[base + 12'd1];
    b2 = mem[base + 12'd2];
    b3 = mem[base + 12'd3];
`ifdef SPI_FLASH_RD_BSWAP_EN
    return {b3, b2, b1, b0};
`else
    return {b0, b1, b2, b3};
`endif
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] a);
    int guard;
    guard = 0;
    while (req_ready !== 1'b1 && guard < 2000) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput("req_ready_wait", 64'(req_ready), 64'(1));
    req_valid = 1'b1;
    req_addr  = a;
    @(posedge clock); #1;
    hs_cyc    = cyc;
    req_valid = 1'b0;
    req_addr  = 24'($urandom);
    exp_addr  = a;
    checkOutput("ss_low_cycle1", 64'(ss), 64'(0));
  endtask

  task automatic finishRequest(input int hold);
    int          guard;
    logic [31:0] held;
    guard = 0;
    while (resp_valid !== 1'b1 && guard < 2000) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput("resp_timeout", 64'(resp_valid), 64'(1));
    checkOutput("latency", 64'(cyc - hs_cyc + 1), 64'(130 * DIV + 1));
    checkOutput("resp_word", 64'(resp_data), 64'(expWord(exp_addr)));
    checkOutput("mosi_cmd_addr", {32'd0, cap_cmd, cap_addr}, {32'd0, 8'h03, exp_addr});
    checkOutput("sck_rises", 64'(last_rises), 64'(64));
    held = resp_data;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      checkOutput("resp_hold", 64'({resp_valid, ss, sck, req_ready, resp_data}),
                  64'({1'b1, 1'b1, 1'b0, 1'b0, held}));
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    resp_ready = 1'b0;
    checkOutput("resp_handshake", 64'({resp_valid, req_ready}), 64'(2'b01));
  endtask

  initial begin
    int          guard;
    logic [23:0] a;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_addr   = 24'd0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    mem[16] = 8'h78; mem[17] = 8'h56; mem[18] = 8'h34; mem[19] = 8'h12;

    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_state", 64'({ss, sck, mosi, req_ready, resp_valid, resp_data}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0}));
    reset = 1'b0;
    @(posedge clock); #1;
    checkOutput("ready_after_reset", 64'(req_ready), 64'(1));

    $display("[TB] directed read of 0x000010 with a 20-cycle consumer stall");
    applyStimulus(24'h000010);
    finishRequest(20);
`ifdef SPI_FLASH_RD_BSWAP_EN
    checkOutput("word_0x10_const", 64'(resp_data), 64'(32'h12345678));
`else
    checkOutput("word_0x10_const", 64'(resp_data), 64'(32'h78563412));
`endif

    $display("[TB] back-to-back reads of 0x000000 and 0x000004");
    applyStimulus(24'h000000);
    finishRequest(0);
    applyStimulus(24'h000004);
    finishRequest(0);
    checkOutput("ss_gap_min2", 64'(last_gap >= 2), 64'(1));

    $display("[TB] request pulse during SHIFT must be ignored");
    applyStimulus(24'h000040);
    repeat (60) @(posedge clock);
    #1;
    req_valid = 1'b1;
    req_addr  = 24'h000080;
    @(posedge clock); #1;
    req_valid = 1'b0;
    finishRequest(2);

    $display("[TB] reset at the 40th sck rise");
    applyStimulus(24'h000030);
    guard = 0;
    while (rise_cnt != 40 && guard < 1000) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput("reached_rise40", 64'(rise_cnt), 64'(40));
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_outputs", 64'({ss, sck, mosi, resp_valid, req_ready}),
                64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0}));
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    applyStimulus(24'h000020);
    finishRequest(3);

    $display("[TB] randomized reads");
    for (int n = 0; n < 5; n++) begin
      a = 24'($urandom_range(0, 4095));
      applyStimulus(a);
      finishRequest(int'($urandom_range(0, 4)));
    end

    checkOutput("stray_sck", 64'(stray_rises), 64'(0));
    checkOutput("ready_during_xfer", 64'(busy_ready), 64'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
